// File: rtl/osd_tracesample_buf.sv
// osd_tracesample_buf
//   Trace sampler with a small elastic buffer in front of the debug
//   packetizer FIFO interface. Samples arriving while the buffer is full,
//   or while a loss count is still waiting to be reported, are dropped and
//   counted. The count is later written into the buffer as one overflow
//   record. That record sits in stream order between the samples taken
//   before the loss and the samples taken after it.
//
// Parameters
//   WIDTH      sample/record data width (WIDTH >= CNT_WIDTH)
//   DEPTH      buffer entries (power of two, >= 2)
//   CNT_WIDTH  loss counter width, saturating at all-ones
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   enable         1 = samples captured or counted, 0 = samples ignored
//   sample_data    trace sample payload
//   sample_valid   sample present this cycle (source cannot be stalled)
//   fifo_data      head entry: sample, or zero-extended loss count
//   fifo_overflow  head entry is an overflow record
//   fifo_valid     buffer not empty
//   fifo_ready     downstream accepts the head entry
//   fill_level     number of occupied entries
module osd_tracesample_buf #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           sample_data,
  input  logic                       sample_valid,
  output logic [WIDTH-1:0]           fifo_data,
  output logic                       fifo_overflow,
  output logic                       fifo_valid,
  input  logic                       fifo_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // Each entry is {overflow flag, payload}.
  logic [WIDTH:0]         mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          count;
  logic [CNT_WIDTH-1:0]   ov_counter;

  logic                   full;
  logic                   pop;
  logic                   s;
  logic                   pend;
  logic                   push_rec;
  logic                   push_smp;
  logic                   push;
  logic [WIDTH:0]         wr_entry;
  logic [WIDTH:0]         head;

  // Saturating increment: once all-ones the count sticks rather than wrap.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    full     = (count == LW'(DEPTH));
    pop      = fifo_valid & fifo_ready;
    s        = sample_valid & enable;
    pend     = |ov_counter;
    // Space is judged on the registered count only, so fifo_ready never
    // feeds write acceptance. A pending record has priority over samples;
    // that keeps the record ahead of anything captured after the loss.
    push_rec = pend & ~full;
    push_smp = s & ~full & ~pend;
    push     = push_rec | push_smp;
    wr_entry = push_rec ? {1'b1, WIDTH'(ov_counter)} : {1'b0, sample_data};
  end

  assign head          = mem[rd_ptr];
  assign fifo_valid    = (count != '0);
  assign fifo_data     = fifo_valid ? head[WIDTH-1:0] : '0;
  assign fifo_overflow = fifo_valid & head[WIDTH];
  assign fill_level    = count;

  // Control state: pointers, occupancy and the loss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ov_counter <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      // A sample arriving alongside the record push cannot be stored, so
      // it starts the next loss count.
      if (push_rec)
        ov_counter <= s ? CNT_WIDTH'(1) : '0;
      else if (s && !push_smp)
        ov_counter <= sat_inc(ov_counter);
    end
  end

  // Entry storage; contents are masked at the output while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_osd_tracesample_buf.sv
module tb_osd_tracesample_buf;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 4;
  localparam int LW        = $clog2(DEPTH+1);
  localparam int SAT       = (1 << CNT_WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] sample_data;
  logic             sample_valid;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_overflow;
  logic             fifo_valid;
  logic             fifo_ready;
  logic [LW-1:0]    fill_level;

  osd_tracesample_buf #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .fifo_data     (fifo_data),
    .fifo_overflow (fifo_overflow),
    .fifo_valid    (fifo_valid),
    .fifo_ready    (fifo_ready),
    .fill_level    (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: buffer as a queue, loss count as an integer,
  // and a log of every entry delivered downstream.
  logic [WIDTH:0] mq[$];
  logic [WIDTH:0] out_log[$];
  int unsigned    m_lost;
  int             max_fill;

  function automatic logic [WIDTH:0] ent(input bit f, input int unsigned d);
    return {f, WIDTH'(d)};
  endfunction

  task automatic model_step();
    bit             full, pop, s, do_push;
    logic [WIDTH:0] e;
    if (rst) begin
      mq.delete();
      m_lost = 0;
      return;
    end
    full    = (mq.size() == DEPTH);
    pop     = (mq.size() != 0) && fifo_ready;
    s       = sample_valid && enable;
    do_push = 1'b0;
    e       = '0;
    if (m_lost != 0 && !full) begin
      e       = ent(1'b1, m_lost);
      do_push = 1'b1;
      m_lost  = s ? 1 : 0;
    end else if (s && !full && m_lost == 0) begin
      e       = {1'b0, sample_data};
      do_push = 1'b1;
    end else if (s) begin
      if (m_lost < SAT) m_lost++;
    end
    if (pop)     out_log.push_back(mq.pop_front());
    if (do_push) mq.push_back(e);
  endtask

  task automatic tick();
    logic [WIDTH:0] exp_head;
    @(negedge clk);
    exp_head = (mq.size() != 0) ? mq[0] : '0;
    check_eq("valid", fifo_valid, mq.size() != 0);
    check_eq("data", fifo_data, exp_head[WIDTH-1:0]);
    check_eq("ovf", fifo_overflow, exp_head[WIDTH]);
    check_eq("fill", fill_level, mq.size());
    if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sv, input int unsigned d, input bit rdy);
    sample_valid = sv;
    sample_data  = WIDTH'(d);
    fifo_ready   = rdy;
    tick();
  endtask

  task automatic check_log(input string tag, input logic [WIDTH:0] exp[$]);
    check_eq({tag, "_len"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), out_log[i], exp[i]);
  endtask

  logic [WIDTH:0] exp_q[$];
  bit             found9;

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    fifo_ready   = 1'b0;
    m_lost       = 0;
    max_fill     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_valid", fifo_valid, 0);
    check_eq("rst_data", fifo_data, 0);
    check_eq("rst_ovf", fifo_overflow, 0);
    check_eq("rst_fill", fill_level, 0);

    // 1: pass-through
    out_log.delete(); max_fill = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 'hA0 + i, 1'b1);
    repeat (2) drive(1'b0, 0, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(1'b0, 'hA0 + i));
    check_log("s1", exp_q);
    check_eq("s1_maxfill_le1", max_fill <= 1, 1);

    // 2: fill without loss
    out_log.delete();
    for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b0);
    check_eq("s2_fill4", fill_level, 4);
    check_eq("s2_head", fifo_data, 1);
    repeat (5) drive(1'b0, 0, 1'b1);
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(ent(1'b0, i));
    check_log("s2", exp_q);

    // 3: overflow record ordering
    out_log.delete();
    for (int i = 1; i <= 7; i++) drive(1'b1, i, 1'b0);
    repeat (7) drive(1'b0, 0, 1'b1);
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(ent(1'b0, i));
    exp_q.push_back(ent(1'b1, 3));
    check_log("s3", exp_q);
    check_eq("s3_fill0", fill_level, 0);

    // 4: sample coincident with record push
    out_log.delete();
    for (int i = 1; i <= 7; i++) drive(1'b1, i, 1'b0);
    drive(1'b0, 0, 1'b1);
    drive(1'b1, 'h9, 1'b1);
    repeat (3) drive(1'b0, 0, 1'b1);
    drive(1'b1, 'hB, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b1);
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(ent(1'b0, i));
    exp_q.push_back(ent(1'b1, 3));
    exp_q.push_back(ent(1'b1, 1));
    exp_q.push_back(ent(1'b0, 'hB));
    check_log("s4", exp_q);
    found9 = 1'b0;
    foreach (out_log[i]) if (out_log[i] == ent(1'b0, 'h9)) found9 = 1'b1;
    check_eq("s4_no9", found9, 0);

    // 5: loss counter saturation
    out_log.delete();
    for (int i = 1; i <= 24; i++) drive(1'b1, i, 1'b0);
    repeat (8) drive(1'b0, 0, 1'b1);
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(ent(1'b0, i));
    exp_q.push_back(ent(1'b1, 'hF));
    check_log("s5", exp_q);

    // 6: enable off, then reset with buffered entries and a pending loss
    out_log.delete();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 'h50 + i, 1'b1);
    check_eq("s6_dis_len", out_log.size(), 0);
    check_eq("s6_dis_fill", fill_level, 0);
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) drive(1'b1, i, 1'b0);
    drive(1'b0, 0, 1'b1);
    check_eq("s6_fill3", fill_level, 3);
    out_log.delete();
    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    rst = 1'b0;
    check_eq("s6_rst_valid", fifo_valid, 0);
    check_eq("s6_rst_fill", fill_level, 0);
    repeat (6) drive(1'b0, 0, 1'b1);
    check_eq("s6_no_rec", out_log.size(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      enable       = ($urandom_range(0, 7) != 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_data  = $urandom;
      fifo_ready   = (i % 64 < 32) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;
    sample_valid = 1'b0;
    repeat (12) drive(1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_tracesample_buf.md
Name: osd_tracesample_buf

Overview:
- Parametrised trace sampler with an internal DEPTH-entry buffer and an overflow counter of configurable width.
- Absorbs short back-pressure bursts from the downstream trace packetizer without losing samples.
- When samples are lost, it counts them and inserts a single in-order overflow record carrying the loss count.
- Sits between a core/NoC trace source and the debug packetizer FIFO interface; has a runtime enable.

Parameters:
WIDTH, 32, sample/record data width; WIDTH >= CNT_WIDTH.
DEPTH, 4, buffer entries; power of two, >= 2.
CNT_WIDTH, 16, overflow counter width; saturates at all-ones.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
enable  in  1  1 = samples are captured or counted; 0 = samples are ignored.
sample_data  in  WIDTH  trace sample payload.
sample_valid  in  1  sample present this cycle; no back-pressure to the source.
fifo_data  out  WIDTH  head entry: sample data, or the overflow count zero-extended.
fifo_overflow  out  1  head entry is an overflow record.
fifo_valid  out  1  buffer not empty.
fifo_ready  in  1  downstream accepts the head entry.
fill_level  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
Reset and reset mid-operation:
- Reset is synchronous and active-high, sampled on posedge clk.
- Reset empties the buffer, sets count = 0 and ov_counter = 0.
- After reset: fifo_valid = 0, fifo_overflow = 0, fifo_data = 0, fill_level = 0.
- Reset mid-operation discards all buffered entries and any pending loss count; no overflow record is emitted for them.

Entry format:
- Each entry holds {flag, WIDTH data}.
- fifo_data and fifo_overflow are forced to 0 while the buffer is empty.

Per-cycle definitions:
- full = (count == DEPTH), from the registered count.
- pop = fifo_valid & fifo_ready.
- s = sample_valid & enable.
- pend = (ov_counter != 0).

Write priority, one write per cycle:
1. pend & !full: push an overflow record {1, zero-extended ov_counter}.
   - Then ov_counter <= s ? 1 : 0, because the concurrent sample cannot be written and is counted as lost.
2. Else s & !full & !pend: push {0, sample_data}.
3. Else s, i.e. full or pend: the sample is lost.
   - ov_counter <= ov_counter + 1, unless ov_counter is all-ones; it then holds (saturation).

Full-buffer rule:
- A push is allowed only when !full, even if pop is asserted in the same cycle.
- There is no combinational path from fifo_ready to write acceptance.

Ordering:
- An overflow record always follows all samples accepted before the loss.
- It always precedes any sample accepted after the loss.

Pop and count:
- Pop removes the head on posedge.
- Simultaneous push and pop keeps count unchanged.
- fill_level = count, registered.

Latency:
- A sample accepted in cycle N appears at the head in cycle N+1 if the buffer was empty.
- fifo_valid is registered-derived; there is no combinational path from sample to output.

Enable:
- enable = 0 ignores samples: they are neither pushed nor counted.
- A pending overflow record is still pushed when space is available.
- Buffered entries still drain.

Pointers:
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- count is tracked separately to distinguish full from empty.

Downstream contract:
- fifo_data and fifo_overflow are stable while fifo_valid & !fifo_ready.
- No head entry is dropped or altered until it is popped.

Test Plan:
1. Pass-through (WIDTH=32, DEPTH=4): fifo_ready=1, samples 0xA0..0xA7 on consecutive cycles -> same 8 values out, each 1 cycle later; fifo_overflow=0 throughout; fill_level never exceeds 1.
2. Fill with no loss: fifo_ready=0, 4 samples 0x1..0x4 -> fill_level=4, head=0x1; then fifo_ready=1 -> outputs 0x1,0x2,0x3,0x4 with fifo_overflow=0.
3. Overflow record ordering: fifo_ready=0, 7 samples 0x1..0x7 -> 0x1..0x4 buffered, 3 lost; fifo_ready=1 with no new samples -> output 0x1,0x2,0x3,0x4, then a record {fifo_overflow=1, fifo_data=3}; fill_level returns to 0.
4. Record push coincident with sample: while the record from scenario 3 is being pushed, assert sample 0x9 -> record data=3, then a second record with data=1; sample 0x9 is never output; the next sample 0xB passes with flag 0.
5. Saturation (CNT_WIDTH=4): hold fifo_ready=0 for 4+20 samples -> record data=0xF; the counter neither wraps to 0 nor produces extra records.
6. Enable and reset: enable=0 with 10 samples -> no entries, no record. Reset asserted with fill_level=3 and ov_counter=2 -> next cycle fifo_valid=0, fill_level=0, and no record is emitted after reset deasserts.
